// File: rtl/dmshr_file_if.sv
// dmshr_file_if: request bus between the dcache front end and the MSHR file.
//   master : LSQ/dcache side, drives the N miss-request lanes, reads req_accept.
//   slave  : dmshr_file side, reads the requests, drives req_accept.
// Per lane: req_valid, req_addr (byte address), req_is_store, req_size,
// req_data (store data), req_id (LSQ index), req_accept (queued this cycle).

`ifndef N
`define N 2
`endif
`ifndef DCACHE_BLOCK_OFFSET_BITS
`define DCACHE_BLOCK_OFFSET_BITS 3
`endif

interface dmshr_file_if #(
  parameter int N       = `N,
  parameter int ID_BITS = 5
);
  logic [N-1:0]              req_valid;
  logic [N-1:0][31:0]        req_addr;
  logic [N-1:0]              req_is_store;
  logic [N-1:0][1:0]         req_size;
  logic [N-1:0][31:0]        req_data;
  logic [N-1:0][ID_BITS-1:0] req_id;
  logic [N-1:0]              req_accept;

  modport master (
    output req_valid, req_addr, req_is_store, req_size, req_data, req_id,
    input  req_accept
  );

  modport slave (
    input  req_valid, req_addr, req_is_store, req_size, req_data, req_id,
    output req_accept
  );
endinterface

// File: rtl/dmshr_file.sv
// dmshr_file: parametrised data-cache miss-status holding register file.
// Tracks up to SIZE outstanding block misses, each with a QDEPTH-deep FIFO of
// LSQ targets. Merges same-block misses (also across ports in one cycle),
// issues block loads to memory with tag-0 retry, fills the cache the cycle the
// data tag returns, then replays up to N targets per cycle on the drain lanes.
// Ports:
//   clock, reset (async, active-low), squash, mem_block
//   req_if            : N request lanes (dmshr_file_if.slave)
//   proc2Dmem_*       : memory command / block address
//   Dmem2proc_*       : transaction tag, data tag, returning block
//   fill_*            : cache fill write (combinational from the data tag)
//   drain_*           : N target replay lanes
//   full              : no INVALID entry

`ifndef N
`define N 2
`endif
`ifndef DCACHE_BLOCK_OFFSET_BITS
`define DCACHE_BLOCK_OFFSET_BITS 3
`endif

module dmshr_file #(
  parameter int N       = `N,
  parameter int SIZE    = 8,
  parameter int QDEPTH  = 4,
  parameter int ID_BITS = 5
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        squash,
  input  logic                                        mem_block,
  dmshr_file_if.slave                                 req_if,
  output logic [1:0]                                  proc2Dmem_command,
  output logic [31:0]                                 proc2Dmem_addr,
  input  logic [3:0]                                  Dmem2proc_transaction_tag,
  input  logic [3:0]                                  Dmem2proc_data_tag,
  input  logic [63:0]                                 Dmem2proc_data,
  output logic                                        fill_valid,
  output logic [31:0]                                 fill_addr,
  output logic [63:0]                                 fill_data,
  output logic [N-1:0]                                drain_valid,
  output logic [N-1:0][ID_BITS-1:0]                   drain_id,
  output logic [N-1:0]                                drain_is_store,
  output logic [N-1:0][`DCACHE_BLOCK_OFFSET_BITS-1:0] drain_offset,
  output logic [N-1:0][1:0]                           drain_size,
  output logic [N-1:0][31:0]                          drain_data,
  output logic                                        full
);

  localparam int OFS_W = `DCACHE_BLOCK_OFFSET_BITS;
  localparam int BA_W  = 32 - OFS_W;
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;

  typedef enum logic [1:0] {
    ST_INVALID,
    ST_PENDING,
    ST_WAIT_DATA,
    ST_DRAIN
  } entry_state_t;

  // Control state (reset)
  entry_state_t      st_r    [SIZE];
  logic [PTR_W-1:0]  head_r  [SIZE];
  logic [PTR_W-1:0]  tail_r  [SIZE];
  logic [CNT_W-1:0]  cnt_r   [SIZE];
  logic [QDEPTH-1:0] live_r  [SIZE];
  entry_state_t      st_nx   [SIZE];
  logic [PTR_W-1:0]  head_nx [SIZE];
  logic [PTR_W-1:0]  tail_nx [SIZE];
  logic [CNT_W-1:0]  cnt_nx  [SIZE];
  logic [QDEPTH-1:0] live_nx [SIZE];

  // Payload state (no reset; only meaningful under the control state)
  logic [BA_W-1:0]                   ba_r     [SIZE];
  logic [3:0]                        tag_r    [SIZE];
  logic [QDEPTH-1:0]                 is_st_r  [SIZE];
  logic [QDEPTH-1:0][ID_BITS-1:0]    id_r     [SIZE];
  logic [QDEPTH-1:0][OFS_W-1:0]      ofs_r    [SIZE];
  logic [QDEPTH-1:0][1:0]            size_r   [SIZE];
  logic [QDEPTH-1:0][31:0]           data_r   [SIZE];
  logic [BA_W-1:0]                   ba_nx    [SIZE];
  logic [3:0]                        tag_nx   [SIZE];
  logic [QDEPTH-1:0]                 is_st_nx [SIZE];
  logic [QDEPTH-1:0][ID_BITS-1:0]    id_nx    [SIZE];
  logic [QDEPTH-1:0][OFS_W-1:0]      ofs_nx   [SIZE];
  logic [QDEPTH-1:0][1:0]            size_nx  [SIZE];
  logic [QDEPTH-1:0][31:0]           data_nx  [SIZE];

  // Combinational working variables
  logic             ret_hit, iss_hit, drn_hit;
  int               ret_idx, iss_idx, drn_idx;
  logic             hit, free_ok, conflict;
  int               hit_idx, free_idx, tgt, lane, npop;
  logic [SIZE-1:0]  alloc_m;
  logic [BA_W-1:0]  rba;
  logic [PTR_W-1:0] slot;
  logic [N-1:0]     req_accept_c;

  assign req_if.req_accept = req_accept_c;

  always_comb begin
    st_nx    = st_r;
    head_nx  = head_r;
    tail_nx  = tail_r;
    cnt_nx   = cnt_r;
    live_nx  = live_r;
    ba_nx    = ba_r;
    tag_nx   = tag_r;
    is_st_nx = is_st_r;
    id_nx    = id_r;
    ofs_nx   = ofs_r;
    size_nx  = size_r;
    data_nx  = data_r;

    proc2Dmem_command = CMD_NONE;
    proc2Dmem_addr    = '0;
    fill_valid        = 1'b0;
    fill_addr         = '0;
    fill_data         = '0;
    drain_valid       = '0;
    drain_id          = '0;
    drain_is_store    = '0;
    drain_offset      = '0;
    drain_size        = '0;
    drain_data        = '0;
    req_accept_c      = '0;

    ret_hit = 1'b0; ret_idx = 0;
    iss_hit = 1'b0; iss_idx = 0;
    drn_hit = 1'b0; drn_idx = 0;
    hit = 1'b0; free_ok = 1'b0; conflict = 1'b0;
    hit_idx = 0; free_idx = 0; tgt = -1; lane = 0; npop = 0;
    alloc_m = '0;
    rba     = '0;
    slot    = '0;

    full = 1'b1;
    for (int i = 0; i < SIZE; i++) begin
      if (st_r[i] == ST_INVALID) full = 1'b0;
    end

    // Return: tag 0 on the data bus means nothing is coming back.
    if (Dmem2proc_data_tag != 4'd0) begin
      for (int i = 0; i < SIZE; i++) begin
        if (!ret_hit && st_r[i] == ST_WAIT_DATA && tag_r[i] == Dmem2proc_data_tag) begin
          ret_hit = 1'b1;
          ret_idx = i;
        end
      end
    end
    if (ret_hit) begin
      fill_valid      = 1'b1;
      fill_addr       = {ba_r[ret_idx], {OFS_W{1'b0}}};
      fill_data       = Dmem2proc_data;
      st_nx[ret_idx]  = ST_DRAIN;
    end

    // Issue: lowest PENDING entry; a zero transaction tag means retry.
    for (int i = 0; i < SIZE; i++) begin
      if (!iss_hit && st_r[i] == ST_PENDING) begin
        iss_hit = 1'b1;
        iss_idx = i;
      end
    end
    if (iss_hit && !mem_block) begin
      proc2Dmem_command = CMD_LOAD;
      proc2Dmem_addr    = {ba_r[iss_idx], {OFS_W{1'b0}}};
      if (Dmem2proc_transaction_tag != 4'd0) begin
        st_nx[iss_idx]  = ST_WAIT_DATA;
        tag_nx[iss_idx] = Dmem2proc_transaction_tag;
      end
    end

    // Drain: lowest DRAIN entry pops up to N targets; dead ones take no lane.
    for (int i = 0; i < SIZE; i++) begin
      if (!drn_hit && st_r[i] == ST_DRAIN) begin
        drn_hit = 1'b1;
        drn_idx = i;
      end
    end
    if (drn_hit) begin
      for (int k = 0; k < N; k++) begin
        if (k < int'(cnt_r[drn_idx])) begin
          slot = head_r[drn_idx] + PTR_W'(k);
          if (live_r[drn_idx][slot]) begin
            drain_valid[lane]    = 1'b1;
            drain_id[lane]       = id_r[drn_idx][slot];
            drain_is_store[lane] = is_st_r[drn_idx][slot];
            drain_offset[lane]   = ofs_r[drn_idx][slot];
            drain_size[lane]     = size_r[drn_idx][slot];
            drain_data[lane]     = data_r[drn_idx][slot];
            lane = lane + 1;
          end
        end
      end
      npop = (int'(cnt_r[drn_idx]) > N) ? N : int'(cnt_r[drn_idx]);
      head_nx[drn_idx] = head_r[drn_idx] + PTR_W'(npop);
      cnt_nx[drn_idx]  = cnt_r[drn_idx] - CNT_W'(npop);
      if (cnt_nx[drn_idx] == '0) st_nx[drn_idx] = ST_INVALID;
    end

    // Requests in port order; lower ports' allocations and pushes are visible
    // to higher ports through the *_nx arrays and alloc_m.
    for (int p = 0; p < N; p++) begin
      if (reset && !squash && req_if.req_valid[p]) begin
        rba      = req_if.req_addr[p][31:OFS_W];
        conflict = 1'b0;
        hit      = 1'b0;
        free_ok  = 1'b0;
        hit_idx  = 0;
        free_idx = 0;
        tgt      = -1;
        for (int i = 0; i < SIZE; i++) begin
          // An entry draining now, or starting to drain, takes no new targets.
          if ((st_r[i] == ST_DRAIN || (ret_hit && ret_idx == i)) && ba_r[i] == rba)
            conflict = 1'b1;
          if (!hit && ba_nx[i] == rba &&
              (alloc_m[i] ||
               ((st_r[i] == ST_PENDING || st_r[i] == ST_WAIT_DATA) &&
                !(ret_hit && ret_idx == i)))) begin
            hit     = 1'b1;
            hit_idx = i;
          end
          // Only entries already INVALID in registered state are reusable.
          if (!free_ok && st_r[i] == ST_INVALID && !alloc_m[i]) begin
            free_ok  = 1'b1;
            free_idx = i;
          end
        end
        if (!conflict) begin
          if (hit) begin
            if (cnt_nx[hit_idx] < CNT_W'(QDEPTH)) tgt = hit_idx;
          end else if (free_ok) begin
            tgt               = free_idx;
            alloc_m[free_idx] = 1'b1;
            st_nx[free_idx]   = ST_PENDING;
            ba_nx[free_idx]   = rba;
          end
        end
        if (tgt >= 0) begin
          slot                = tail_nx[tgt];
          live_nx[tgt][slot]  = 1'b1;
          is_st_nx[tgt][slot] = req_if.req_is_store[p];
          id_nx[tgt][slot]    = req_if.req_id[p];
          ofs_nx[tgt][slot]   = req_if.req_addr[p][OFS_W-1:0];
          size_nx[tgt][slot]  = req_if.req_size[p];
          data_nx[tgt][slot]  = req_if.req_data[p];
          tail_nx[tgt]        = tail_nx[tgt] + PTR_W'(1);
          cnt_nx[tgt]         = cnt_nx[tgt] + CNT_W'(1);
          req_accept_c[p]     = 1'b1;
        end
      end
    end

    // Squash kills queued loads after this cycle's drain used the old bits.
    if (squash) begin
      for (int i = 0; i < SIZE; i++) begin
        live_nx[i] = live_nx[i] & is_st_nx[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_r   <= '{default: ST_INVALID};
      head_r <= '{default: '0};
      tail_r <= '{default: '0};
      cnt_r  <= '{default: '0};
      live_r <= '{default: '0};
    end else begin
      st_r   <= st_nx;
      head_r <= head_nx;
      tail_r <= tail_nx;
      cnt_r  <= cnt_nx;
      live_r <= live_nx;
    end
  end

  always_ff @(posedge clock) begin
    ba_r    <= ba_nx;
    tag_r   <= tag_nx;
    is_st_r <= is_st_nx;
    id_r    <= id_nx;
    ofs_r   <= ofs_nx;
    size_r  <= size_nx;
    data_r  <= data_nx;
  end

endmodule
